// File: rtl/me_pkg.sv
// Shared motion-estimation types: geometry constants, packed SAD result and pass state.
// Also imported by the downstream minimum-search tree.
package me_pkg;
  localparam int PIX_W    = 8;
  localparam int BLK_PIX  = 64;
  localparam int NUM_CAND = 16;
  localparam int SAD_W    = 14;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = $clog2(BLK_PIX);

  typedef struct packed {
    logic [SAD_W-1:0] sad;
    logic [IDX_W-1:0] y_idx;
  } sad_res_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_HOLD} state_e;

  // Larger minus smaller keeps the result unsigned without a sign bit.
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction
endpackage

// File: rtl/sad_accum_array_if.sv
// Control, pixel-beat and result handshake bundle of the SAD producer.
// slave = the SAD array, master = the pass controller / pixel source.
interface sad_accum_array_if;
  import me_pkg::*;

  logic                            start;
  logic [IDX_W-1:0]                y_offset;
  logic                            busy;
  logic                            pix_valid;
  logic                            pix_ready;
  logic [PIX_W-1:0]                cur_pix;
  logic [NUM_CAND*PIX_W-1:0]       ref_pix;
  logic                            sad_valid;
  logic                            sad_ready;
  sad_res_t [NUM_CAND-1:0]         sad;

  modport slave (
    input  start, y_offset, pix_valid, cur_pix, ref_pix, sad_ready,
    output busy, pix_ready, sad_valid, sad
  );

  modport master (
    output start, y_offset, pix_valid, cur_pix, ref_pix, sad_ready,
    input  busy, pix_ready, sad_valid, sad
  );
endinterface

// File: rtl/sad_lane.sv
// One candidate lane: registered |cur-ref| (stage 1) feeding a 14-bit accumulator (stage 2).
// o_acc_nxt exposes the post-add value so the top can capture the final sum during DRAIN.
module sad_lane
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_cur,
  input  logic [PIX_W-1:0] i_ref,
  output logic [SAD_W-1:0] o_acc_nxt
);
  logic [PIX_W-1:0] r_diff;
  logic             r_dv;
  logic [SAD_W-1:0] r_acc;
  logic [SAD_W-1:0] w_acc_nxt;

  // 64 * 255 fits in SAD_W bits, so the plain add can never wrap.
  assign w_acc_nxt = r_dv ? (r_acc + SAD_W'(r_diff)) : r_acc;
  assign o_acc_nxt = w_acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_diff <= '0;
      r_dv   <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_dv <= i_clr ? 1'b0 : i_en;
      if (i_en) r_diff <= abs_diff(i_cur, i_ref);
      r_acc <= i_clr ? '0 : w_acc_nxt;
    end
  end
endmodule

// File: rtl/sad_accum_array.sv
// 16-candidate SAD producer: FSM, beat counter, y latch and packed result registers
// around an array of sad_lane instances.
module sad_accum_array
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  sad_accum_array_if.slave bus
);
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ACCUM = ST_ACCUM;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  logic [1:0]                     r_state;
  logic [1:0]                     w_state_nxt;
  logic [CNT_W-1:0]               r_cnt;
  logic [IDX_W-1:0]               r_y;
  sad_res_t [NUM_CAND-1:0]        r_sad;
  logic [NUM_CAND-1:0][SAD_W-1:0] w_acc_nxt;
  logic                           w_beat;
  logic                           w_accept;
  logic                           w_clr;
  logic                           w_last;

  assign w_beat   = (r_state == S_ACCUM) && bus.pix_valid;
  assign w_accept = (r_state == S_HOLD) && bus.sad_ready;
  // A new pass may start from IDLE or in the same cycle a held result is taken.
  assign w_clr    = bus.start && ((r_state == S_IDLE) || w_accept);
  assign w_last   = w_beat && (r_cnt == CNT_W'(BLK_PIX - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_HOLD;
      S_HOLD:  if (bus.sad_ready) w_state_nxt = bus.start ? S_ACCUM : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_sad   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr)       r_cnt <= '0;
      else if (w_beat) r_cnt <= r_cnt + CNT_W'(1);
      if (w_clr) r_y <= bus.y_offset;
      // Capture the post-add sums so the last difference is included.
      if (r_state == S_DRAIN) begin
        for (int i = 0; i < NUM_CAND; i++) begin
          r_sad[i].sad   <= w_acc_nxt[i];
          r_sad[i].y_idx <= r_y;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_lane
    sad_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_clr),
      .i_en      (w_beat),
      .i_cur     (bus.cur_pix),
      .i_ref     (bus.ref_pix[g*PIX_W +: PIX_W]),
      .o_acc_nxt (w_acc_nxt[g])
    );
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.pix_ready = (r_state == S_ACCUM);
  assign bus.sad_valid = (r_state == S_HOLD);
  assign bus.sad       = r_sad;
endmodule

// File: tb/tb_sad_accum_array.sv
// Randomized bench for sad_accum_array; expected SADs come from a plain sum-of-|diff| model.
module tb_sad_accum_array;
  import me_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cur_a [BLK_PIX];
  int   ref_a [BLK_PIX][NUM_CAND];

  sad_accum_array_if bus();

  sad_accum_array dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0 random, 1 ramp (cur 100, ref 100+i), 2 cur 0 / ref 255, 3 cur 255 / ref 0
  task automatic fill(input int mode);
    for (int k = 0; k < BLK_PIX; k++) begin
      case (mode)
        1:       cur_a[k] = 100;
        2:       cur_a[k] = 0;
        3:       cur_a[k] = 255;
        default: cur_a[k] = int'($urandom_range(255));
      endcase
      for (int i = 0; i < NUM_CAND; i++) begin
        case (mode)
          1:       ref_a[k][i] = 100 + i;
          2:       ref_a[k][i] = 255;
          3:       ref_a[k][i] = 0;
          default: ref_a[k][i] = int'($urandom_range(255));
        endcase
      end
    end
  endtask

  function automatic int model_sad(input int lane);
    int s = 0;
    for (int k = 0; k < BLK_PIX; k++)
      s += (cur_a[k] > ref_a[k][lane]) ? cur_a[k] - ref_a[k][lane] : ref_a[k][lane] - cur_a[k];
    return s;
  endfunction

  task automatic drive_junk(input logic valid);
    bus.pix_valid = valid;
    bus.cur_pix   = 8'($urandom);
    for (int i = 0; i < NUM_CAND; i++) bus.ref_pix[i*8 +: 8] = 8'($urandom);
  endtask

  task automatic drive_beat(input int k);
    bus.pix_valid = 1'b1;
    bus.cur_pix   = 8'(cur_a[k]);
    for (int i = 0; i < NUM_CAND; i++) bus.ref_pix[i*8 +: 8] = 8'(ref_a[k][i]);
  endtask

  task automatic check_result(input logic [3:0] y, input string tag);
    logic [17:0] e;
    for (int i = 0; i < NUM_CAND; i++) begin
      e = {14'(model_sad(i)), y};
      chk($sformatf("%s_sad%0d", tag, i), 32'(bus.sad[i]), 32'(e));
    end
  endtask

  // gap_mode: 0 none, 1 one bubble before every beat, 2 random bubbles
  task automatic run_pass(input logic [3:0] y, input bit do_start, input int gap_mode,
                          input bit poke_start, input string tag);
    if (do_start) begin
      bus.start = 1'b1; bus.y_offset = y;
      tick();
      bus.start = 1'b0; bus.y_offset = 4'($urandom);
    end
    for (int k = 0; k < BLK_PIX; k++) begin
      int gaps;
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        drive_junk(1'b0);
        if (poke_start && k == 20) begin bus.start = 1'b1; bus.y_offset = 4'($urandom); end
        tick();
        bus.start = 1'b0;
      end
      drive_beat(k);
      chk({tag, "_pix_ready"}, 32'(bus.pix_ready), 32'd1);
      tick();
    end
    drive_junk(1'b0);
    chk({tag, "_lat_n1"}, 32'(bus.sad_valid), 32'd0);
    tick();
    chk({tag, "_lat_n2"}, 32'(bus.sad_valid), 32'd1);
    check_result(y, tag);
  endtask

  task automatic release_idle(input string tag);
    bus.sad_ready = 1'b1; bus.start = 1'b0;
    tick();
    bus.sad_ready = 1'b0;
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] y;
    bus.start = 1'b0; bus.y_offset = '0; bus.sad_ready = 1'b0;
    drive_junk(1'b0);

    // reset held with random inputs
    for (int c = 0; c < 5; c++) begin
      bus.start = 1'($urandom); bus.sad_ready = 1'($urandom);
      drive_junk(1'($urandom));
      tick();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
      chk("rst_sad_valid", 32'(bus.sad_valid), 32'd0);
      chk("rst_sad_any", 32'(|bus.sad), 32'd0);
    end
    bus.start = 1'b0; bus.sad_ready = 1'b0; drive_junk(1'b0);
    @(negedge clk); #2 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_sad_any", 32'(|bus.sad), 32'd0);
    end

    // lane ramp, y=5: sad_i = 64*i
    fill(1);
    run_pass(4'd5, 1'b1, 0, 1'b0, "ramp");
    chk("ramp_sad3_const", 32'(bus.sad[3].sad), 32'd192);
    chk("ramp_sad15_const", 32'(bus.sad[15].sad), 32'd960);

    // hold stable with sad_ready low for 10 cycles
    for (int c = 0; c < 10; c++) begin
      drive_junk(1'($urandom));
      bus.start = 1'b0;
      tick();
      chk("hold_valid", 32'(bus.sad_valid), 32'd1);
      chk("hold_sad0", 32'(bus.sad[0]), 32'({14'd0, 4'd5}));
      chk("hold_sad15", 32'(bus.sad[15]), 32'({14'd960, 4'd5}));
    end
    // back-to-back pass: accept + start in the same cycle
    bus.sad_ready = 1'b1; bus.start = 1'b1; bus.y_offset = 4'd9; drive_junk(1'b0);
    tick();
    bus.sad_ready = 1'b0; bus.start = 1'b0;
    chk("b2b_pix_ready", 32'(bus.pix_ready), 32'd1);
    chk("b2b_sad_valid", 32'(bus.sad_valid), 32'd0);
    fill(0);
    run_pass(4'd9, 1'b0, 0, 1'b0, "b2b");
    release_idle("b2b");

    // max value, both directions
    fill(2);
    run_pass(4'd15, 1'b1, 0, 1'b0, "max");
    chk("max_sad7_const", 32'(bus.sad[7].sad), 32'd16320);
    release_idle("max");
    fill(3);
    run_pass(4'd0, 1'b1, 0, 1'b0, "swap");
    chk("swap_sad12_const", 32'(bus.sad[12].sad), 32'd16320);
    release_idle("swap");

    // alternating stalls, start pulsed during ACCUM must be ignored
    fill(0);
    run_pass(4'd3, 1'b1, 1, 1'b1, "stall");
    release_idle("stall");
    for (int c = 0; c < 4; c++) begin
      drive_junk(1'b1);
      tick();
      chk("stall_no_second", 32'(bus.busy), 32'd0);
    end
    drive_junk(1'b0);

    // async reset at beat 30
    fill(0);
    bus.start = 1'b1; bus.y_offset = 4'd7;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 30; k++) begin drive_beat(k); tick(); end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_pix_ready", 32'(bus.pix_ready), 32'd0);
    chk("arst_sad_any", 32'(|bus.sad), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      drive_junk(1'b1);
      tick();
      chk("arst_no_valid", 32'(bus.sad_valid), 32'd0);
    end
    drive_junk(1'b0);
    fill(0);
    run_pass(4'd2, 1'b1, 0, 1'b0, "post_arst");
    release_idle("post_arst");

    // random passes with random bubbles
    for (int p = 0; p < 3; p++) begin
      y = 4'($urandom);
      fill(0);
      run_pass(y, 1'b1, 2, 1'b0, $sformatf("rnd%0d", p));
      release_idle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sad_accum_array.md
Name: sad_accum_array

Overview:
- Producer side of the motion-estimation SAD/compare path: computes 16 candidate SADs in parallel for one 8x8 current block against 16 horizontally adjacent reference candidates at one vertical offset.
- Presents the 16 packed results with a valid/ready handshake to the downstream minimum-search tree.
- One invocation covers one vertical offset; the controller calls it 16 times (y = 0..15) per block.

Parameters:
- PIX_W, 8, pixel bit width
- BLK_PIX, 64, pixels per block (8x8)
- NUM_CAND, 16, parallel candidates (horizontal offsets x = 0..15)
- SAD_W, 14, SAD field width (64*255 = 16320 fits)
- IDX_W, 4, offset index width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- start  input  1  one-cycle pulse; begins a block pass; sampled only when idle, or in HOLD together with an accepted output
- y_offset  input  4  vertical offset of this pass; latched on accepted start
- busy  output  1  high whenever state != IDLE
- pix_valid  input  1  pixel beat valid
- pix_ready  output  1  high in ACCUM only
- cur_pix  input  8  current-block pixel, raster order
- ref_pix  input  128  16 reference pixels; lane i = bits [8i+7:8i], candidate x = i
- sad_valid  output  1  result valid
- sad_ready  input  1  downstream accepts result
- sad_0 .. sad_15  output  18 each  {SAD[13:0], y_offset[3:0]} for candidate x = i

Behaviour:
- Reset (async, rst=1) values: state=IDLE, busy=0, pix_ready=0, sad_valid=0, all sad_i=0, beat counter=0, latched y_offset=0.
- FSM:
  - IDLE --start--> ACCUM. Accumulators and counter clear; y_offset latched.
  - ACCUM: each beat with pix_valid&pix_ready increments the counter and feeds the abs-diff stage. The 64th beat (count 63) -> DRAIN.
  - DRAIN: one cycle; the final registered difference is added -> HOLD.
  - HOLD: sad_valid=1; sad_i stable until sad_ready.
    - sad_ready & start -> ACCUM (back-to-back pass; clears and relatches in that cycle).
    - sad_ready & !start -> IDLE.
- Datapath, two stages:
  - Stage 1 registers |cur_pix - ref_pix[i]| (8-bit unsigned, computed as larger minus smaller) with a valid bit.
  - Stage 2 adds it to a 14-bit accumulator.
- Latency: last beat accepted in cycle N -> sad_valid=1 in cycle N+2.
- Throughput: 1 beat/cycle while pix_valid is held; one pass takes 66 cycles minimum with a back-to-back start.
- Gaps: pix_valid=0 in ACCUM inserts a stall bubble. The stage-1 valid bit stays 0, so the accumulators do not change.
- Width: max sum 16320 < 2^14, so there is no overflow and no saturation logic. A wider accumulator is not permitted.
- start in ACCUM or DRAIN is ignored, with no queuing. start in IDLE with pix_valid already high: the first beat is accepted the cycle after start.
- pix_valid while not in ACCUM is ignored; pix_ready=0 there.
- sad_i register updates only on the transition DRAIN->HOLD. Outputs retain their last values in IDLE and ACCUM; sad_valid qualifies them.
- rst asserted mid-pass: immediate return to reset values; the partial SAD is discarded and no result is emitted.

Decomposition:
- Package me_pkg:
  - constants PIX_W, BLK_PIX, NUM_CAND, SAD_W, IDX_W
  - packed result type {sad, y_idx} (18 bits)
  - state enum {IDLE, ACCUM, DRAIN, HOLD}
  - shared by the downstream compare tree
- Sub-module sad_lane: one candidate's abs-diff register plus accumulator, with clear and enable inputs. Instantiated NUM_CAND times under generate.
- The top holds the FSM, beat counter, y_offset latch and output packing.

Test Plan:
- Reset: hold rst with random inputs -> busy=0, pix_ready=0, sad_valid=0, all sad_i=0. Release rst mid-cycle -> outputs stay 0 until start.
- Lane ramp: start with y_offset=5; 64 beats with cur_pix=100 and ref lane i=100+i -> sad_i = {64*i, 4'd5}, e.g. sad_3[17:4]=192, sad_15[17:4]=960. sad_valid rises exactly 2 cycles after beat 64.
- Max value: cur_pix=0, all ref=255, 64 beats -> every sad_i[17:4]=16320, no wrap. Swap cur/ref -> same 16320.
- Handshake: sad_ready=0 for 10 cycles in HOLD -> sad_i and sad_valid stable. Then sad_ready=1 with start=1 and y_offset=9 -> next cycle ACCUM, pix_ready=1. Second result carries y=9 with accumulators fresh (no carry-over).
- Stalls and ignored start: pix_valid toggled 1/0 for 128 cycles (64 valid beats) with start pulsed during ACCUM -> single result, equal to the gap-free run; no second pass starts.
- Async reset at beat 30 -> busy=0 immediately, no sad_valid ever. A following full pass gives a correct SAD with no residue from the aborted pass.
